// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads memory combinationally and queues {pc, inst} for decode.
// Latency 1 cycle from read to buffer head. Reads stall when the buffer is full and not popping.
module fetch_unit #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h01000000),
  parameter int                MEM_BYTES = 1048576,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] imem_addr_o,
  output logic              imem_read_en_o,
  input  logic [DWIDTH-1:0] imem_data_i,
  output logic              inst_valid_o,
  output logic [DWIDTH-1:0] inst_o,
  output logic [AWIDTH-1:0] pc_o,
  input  logic              inst_ready_i,
  input  logic              redirect_valid_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              fault_o,
  output logic [1:0]        fault_code_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HALT  = 1'b1;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_ALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE = 2'b10;

  // One extra bit so the upper bound cannot wrap for memories near the top of the address space.
  localparam logic [AWIDTH:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [AWIDTH:0] HI_ADDR = LO_ADDR + (AWIDTH+1)'(MEM_BYTES) - (AWIDTH+1)'(4);

  logic [AWIDTH-1:0] r_pc;
  logic [0:0]        r_state;
  logic              r_fault;
  logic [1:0]        r_fault_code;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [AWIDTH-1:0] r_buf_pc   [BUF_DEPTH];
  logic [DWIDTH-1:0] r_buf_inst [BUF_DEPTH];

  logic w_fetching;
  logic w_valid;
  logic w_pop;
  logic w_can_push;
  logic w_in_range;
  logic w_redirect;
  logic w_misaligned;
  logic w_push;
  logic w_out_of_range;

  assign w_fetching     = (r_state == S_FETCH);
  assign w_valid        = (r_count != '0);
  assign w_pop          = w_valid & inst_ready_i;
  assign w_can_push     = (r_count < CW'(BUF_DEPTH)) | w_pop;
  assign w_in_range     = ({1'b0, r_pc} >= LO_ADDR) && ({1'b0, r_pc} <= HI_ADDR);
  // Redirects only matter while fetching; in HALT they are dropped entirely.
  assign w_redirect     = w_fetching & redirect_valid_i;
  assign w_misaligned   = (redirect_pc_i[1:0] != 2'b00);
  assign w_push         = ~rst & w_fetching & w_can_push & ~redirect_valid_i & w_in_range;
  assign w_out_of_range = w_fetching & w_can_push & ~redirect_valid_i & ~w_in_range;

  assign imem_addr_o    = r_pc;
  assign imem_read_en_o = w_push;
  assign inst_valid_o   = w_valid;
  assign inst_o         = w_valid ? r_buf_inst[r_rd_ptr] : '0;
  assign pc_o           = w_valid ? r_buf_pc[r_rd_ptr]   : '0;
  assign fault_o        = r_fault;
  assign fault_code_o   = r_fault_code;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]   <= r_pc;
      r_buf_inst[r_wr_ptr] <= imem_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= BASE_ADDR;
      r_state      <= S_FETCH;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
    end else if (w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      if (w_misaligned) begin
        r_state      <= S_HALT;
        r_fault      <= 1'b1;
        r_fault_code <= FC_ALIGN;
      end else begin
        r_pc <= redirect_pc_i;
      end
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_pc     <= r_pc + AWIDTH'(4);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_out_of_range) begin
        r_state      <= S_HALT;
        r_fault      <= 1'b1;
        r_fault_code <= FC_RANGE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboarded random stream with redirects, plus directed boundary cases.
// A second instance with a 16-byte memory exercises the out-of-range fault.
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h01000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;

  // Instance A: full-size memory
  logic        rst_a = 1'b0;
  logic [31:0] addr_a, data_a, inst_a, pc_a, rpc_a;
  logic        ren_a, vld_a, rdy_a, redir_a, fault_a;
  logic [1:0]  code_a;

  // Instance B: 16-byte memory
  logic        rst_b = 1'b0;
  logic [31:0] addr_b, data_b, inst_b, pc_b;
  logic        ren_b, vld_b, rdy_b, fault_b;
  logic [1:0]  code_b;

  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      BASE:          return 32'h00000013;
      BASE + 32'd4:  return 32'h00100093;
      BASE + 32'd8:  return 32'h00200113;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h5a5a0000;
    endcase
  endfunction

  assign data_a = mem_word(addr_a);
  assign data_b = mem_word(addr_b);

  fetch_unit dut_a (
    .clk(clk), .rst(rst_a),
    .imem_addr_o(addr_a), .imem_read_en_o(ren_a), .imem_data_i(data_a),
    .inst_valid_o(vld_a), .inst_o(inst_a), .pc_o(pc_a), .inst_ready_i(rdy_a),
    .redirect_valid_i(redir_a), .redirect_pc_i(rpc_a),
    .fault_o(fault_a), .fault_code_o(code_a)
  );

  fetch_unit #(.MEM_BYTES(16)) dut_b (
    .clk(clk), .rst(rst_b),
    .imem_addr_o(addr_b), .imem_read_en_o(ren_b), .imem_data_i(data_b),
    .inst_valid_o(vld_b), .inst_o(inst_b), .pc_o(pc_b), .inst_ready_i(rdy_b),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0),
    .fault_o(fault_b), .fault_code_o(code_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected delivery after (re)start: a contiguous run of word addresses from the start point.
  task automatic seed(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 900; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic restart_a(input logic rdy);
    rst_a   = 1'b1;
    redir_a = 1'b0;
    tick();
    tick();
    rst_a = 1'b0;
    rdy_a = rdy;
    seed(BASE);
  endtask

  // Scoreboard monitor: every accepted head must be the next expected {pc, inst}.
  always @(negedge clk) begin
    if (!rst_a && vld_a && rdy_a && !redir_a) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got pc %0h expected no delivery", pc_a);
      end else begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        chk("sb_pc", pc_a, epc);
        chk("sb_inst", inst_a, mem_word(epc));
        n_pop++;
      end
    end
  end

  initial begin
    rdy_a = 1'b1; redir_a = 1'b0; rpc_a = 32'h0; rdy_b = 1'b1;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #2;
    chk("rst_valid", vld_a, 0);
    chk("rst_ren", ren_a, 0);
    chk("rst_fault", {fault_a, code_a}, 0);
    chk("rst_pc_o", pc_a, 0);
    chk("rst_inst_o", inst_a, 0);
    chk("rst_addr", addr_a, BASE);

    // Reset and stream
    tick();
    rst_a = 1'b0;
    seed(BASE);
    @(negedge clk);
    chk("c0_ren", ren_a, 1);
    chk("c0_valid", vld_a, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("stream_valid", vld_a, 1);
      chk("stream_pc", pc_a, BASE + 32'(4 * k));
      chk("stream_inst", inst_a, mem_word(BASE + 32'(4 * k)));
      chk("stream_ren", ren_a, 1);
    end

    // Backpressure, then full buffer with simultaneous pop
    restart_a(1'b0);
    @(negedge clk);
    chk("bp_c0_ren", ren_a, 1);
    tick();
    @(negedge clk);
    chk("bp_c1_ren", ren_a, 1);
    for (int k = 2; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("bp_full_ren", ren_a, 0);
      chk("bp_head_pc", pc_a, BASE);
    end
    tick();
    rdy_a = 1'b1;
    @(negedge clk);
    chk("fullpop_ren", ren_a, 1);
    chk("fullpop_pc", pc_a, BASE);
    for (int k = 1; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("drain_pc", pc_a, BASE + 32'(4 * k));
      chk("drain_ren", ren_a, 1);
    end

    // Aligned redirect at cycle 4
    restart_a(1'b1);
    for (int k = 0; k < 4; k++) tick();
    redir_a = 1'b1;
    rpc_a   = 32'h01000100;
    seed(32'h01000100);
    @(negedge clk);
    chk("redir_ren", ren_a, 0);
    tick();
    redir_a = 1'b0;
    @(negedge clk);
    chk("redir_c5_valid", vld_a, 0);
    chk("redir_c5_addr", addr_a, 32'h01000100);
    chk("redir_c5_ren", ren_a, 1);
    tick();
    @(negedge clk);
    chk("redir_c6_valid", vld_a, 1);
    chk("redir_c6_pc", pc_a, 32'h01000100);

    // Random ready and aligned redirects
    n_pop = 0;
    for (int k = 0; k < 800; k++) begin
      tick();
      rdy_a = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) begin
        redir_a = 1'b1;
        rpc_a   = BASE + 32'(4 * $urandom_range(0, 2000));
        seed(rpc_a);
      end else begin
        redir_a = 1'b0;
      end
    end
    @(negedge clk);
    chk("random_progress", (n_pop >= 200), 1);

    // Misaligned redirect faults; later redirects are ignored
    tick();
    rdy_a   = 1'b1;
    redir_a = 1'b1;
    rpc_a   = 32'h01000102;
    exp_q.delete();
    tick();
    redir_a = 1'b0;
    @(negedge clk);
    chk("mis_fault", fault_a, 1);
    chk("mis_code", code_a, 2'b01);
    chk("mis_valid", vld_a, 0);
    chk("mis_ren", ren_a, 0);
    tick();
    redir_a = 1'b1;
    rpc_a   = 32'h01000200;
    tick();
    redir_a = 1'b0;
    @(negedge clk);
    chk("halt_code", code_a, 2'b01);
    chk("halt_valid", vld_a, 0);
    chk("halt_ren", ren_a, 0);
    chk("halt_addr_not_target", (addr_a == 32'h01000200), 0);
    tick();
    rdy_a = 1'b0;
    rst_a = 1'b1;
    #1;
    chk("rst_clears_fault", {fault_a, code_a}, 0);

    // Out-of-range fault on the 16-byte instance
    tick();
    rst_b = 1'b0;
    @(negedge clk);
    chk("oor_c0_ren", ren_b, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("oor_valid", vld_b, 1);
      chk("oor_pc", pc_b, BASE + 32'(4 * k));
      chk("oor_inst", inst_b, mem_word(BASE + 32'(4 * k)));
    end
    chk("oor_c4_ren", ren_b, 0);
    tick();
    @(negedge clk);
    chk("oor_fault", fault_b, 1);
    chk("oor_code", code_b, 2'b10);
    chk("oor_valid_end", vld_b, 0);
    chk("oor_ren_end", ren_b, 0);

    // Asynchronous reset mid-stream
    tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("mid_valid", vld_b, 1);
    #2;
    rst_b = 1'b1;
    #1;
    chk("async_valid", vld_b, 0);
    chk("async_ren", ren_b, 0);
    chk("async_addr", addr_b, BASE);
    chk("async_fault", {fault_b, code_b}, 0);
    chk("async_pc_o", pc_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the byte-addressable memory in the pd1 core.
- Owns the program counter and drives the memory address and read enable.
- Captures the combinationally returned 32-bit word into a small instruction buffer.
- Presents {pc, instruction} to decode through a valid/ready handshake.
- Handles branch/jump redirects, backpressure and fetch faults.

Parameters:
AWIDTH, 32, address/PC width
DWIDTH, 32, instruction width
BASE_ADDR, 32'h01000000, reset PC and memory base address
MEM_BYTES, 1048576, memory size in bytes; legal fetch range is [BASE_ADDR, BASE_ADDR+MEM_BYTES-4]
BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
imem_addr_o  output  AWIDTH  byte address to memory; always equals current PC
imem_read_en_o  output  1  memory read enable
imem_data_i  input  DWIDTH  combinational read data from memory
inst_valid_o  output  1  buffer head holds a valid instruction
inst_o  output  DWIDTH  instruction at buffer head
pc_o  output  AWIDTH  PC of instruction at buffer head
inst_ready_i  input  1  decode accepts head this cycle
redirect_valid_i  input  1  redirect request from execute
redirect_pc_i  input  AWIDTH  redirect target
fault_o  output  1  sticky fault flag
fault_code_o  output  2  00 none, 01 misaligned redirect, 10 PC out of range

Behaviour:
- Reset (async assert): PC=BASE_ADDR, buffer empty, state=FETCH, fault_o=0, fault_code_o=00, inst_valid_o=0, imem_read_en_o=0 while rst is high; inst_o and pc_o read 0 while empty.
- States:
  - FETCH: normal operation.
  - HALT: fault taken. Exits only via rst.
- Derived terms:
  - pop = inst_valid_o & inst_ready_i.
  - can_push = (count < BUF_DEPTH) | pop. Full-and-pop allows a push in the same cycle.
- imem_read_en_o = (state==FETCH) & can_push & ~redirect_valid_i & PC in range.
- Push: on the posedge where imem_read_en_o=1, write {PC, imem_data_i} at the tail and set PC <= PC+4 (AWIDTH wrap, unsigned).
- Latency: a word read in cycle N appears at the head in cycle N+1 when the buffer was empty. Sustained throughput is 1 instruction/cycle while inst_ready_i=1.
- Ordering: FIFO order. Head outputs are stable while inst_valid_o=1 and inst_ready_i=0.
- Redirect (highest priority; in FETCH or HALT-free paths):
  - On the posedge with redirect_valid_i=1, the buffer is flushed (count=0), there is no push, and a pop that cycle is ignored.
  - If redirect_pc_i[1:0]==0: PC <= redirect_pc_i; fetch from the target starts the next cycle; first target instruction is valid 2 cycles after redirect assertion.
  - If redirect_pc_i[1:0]!=0: PC unchanged, state <= HALT, fault_o <= 1, fault_code_o <= 01.
- Out of range:
  - Condition: in FETCH with can_push=1 and no redirect, while PC < BASE_ADDR or PC > BASE_ADDR+MEM_BYTES-4.
  - Response: no read, state <= HALT, fault_o <= 1, fault_code_o <= 10.
  - Entries already buffered still drain normally in HALT.
- HALT:
  - imem_read_en_o=0; pops still allowed until empty.
  - Redirects are ignored and do not overwrite the fault code.
  - fault_o and fault_code_o are sticky; the first fault wins.
- Reset mid-operation: immediate return to reset values regardless of state or buffer contents; no partial push survives.
- count: log2(BUF_DEPTH)+1 bits; read and write pointers wrap modulo BUF_DEPTH.

Test Plan:
- Reset and stream: memory words 0x00000013, 0x00100093, 0x00200113 at 0x01000000.., rst released, inst_ready_i=1 -> cycle 1: valid=1 pc=0x01000000 inst=0x00000013; cycle 2: pc=0x01000004; cycle 3: pc=0x01000008; imem_read_en_o high every cycle.
- Backpressure: inst_ready_i=0 for 5 cycles after reset -> buffer fills to 2; imem_read_en_o=0 from cycle 2; head held at pc=0x01000000. Raise inst_ready_i -> pcs 0x01000000, 0x01000004, 0x01000008 in consecutive cycles with no duplicates or gaps.
- Full with simultaneous pop: buffer full and inst_ready_i=1 -> push and pop occur in the same cycle; count stays 2; imem_read_en_o=1.
- Redirect: at cycle 4 assert redirect_valid_i with redirect_pc_i=0x01000100 -> buffer flushed, inst_valid_o=0 in cycle 5, imem_addr_o=0x01000100 with read_en in cycle 5, valid pc=0x01000100 in cycle 6.
- Misaligned redirect: redirect_pc_i=0x01000102 -> next cycle fault_o=1, fault_code_o=01, inst_valid_o=0, imem_read_en_o=0. A later redirect to 0x01000200 is ignored. rst clears the fault.
- Out of range: MEM_BYTES=16, stream with inst_ready_i=1 -> 4 instructions delivered (0x01000000..0x0100000C). At PC=0x01000010, fault_code_o=10 and no further reads. Async rst pulse mid-stream -> outputs return to reset values immediately, without waiting for a clock edge.
